// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: two writeback sources share the regfile's single write port.
// It also tracks registers with long-latency results still outstanding and
// raises a decode stall on RAW and WAW hazards.
module rf_wr_arbiter #(
  parameter int ROUND_ROBIN = 1,
  parameter int AW          = 5,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s0_valid,
  output logic          s0_ready,
  input  logic [AW-1:0] s0_addr,
  input  logic [DW-1:0] s0_data,
  input  logic          s1_valid,
  output logic          s1_ready,
  input  logic [AW-1:0] s1_addr,
  input  logic [DW-1:0] s1_data,
  input  logic          issue_vld,
  input  logic [AW-1:0] issue_addr,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr3,
  output logic [DW-1:0] rf_wd3
);

  localparam int NREG = 1 << AW;

  // last_grant_q: 0 = s0 won the last grant, 1 = s1 won it
  logic            last_grant_q;
  logic            rf_we_q;
  logic [AW-1:0]   rf_addr3_q;
  logic [DW-1:0]   rf_wd3_q;
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            grant0;
  logic            grant1;
  logic            hz_rd1;
  logic            hz_rd2;
  logic            hz_waw;
  logic            hz_inflight;
  logic            issue_set;

  // Arbitration: a lone requester always wins; on conflict either rotate or favour s0
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (s0_valid && s1_valid) begin
        if ((ROUND_ROBIN != 0) && !last_grant_q) grant1 = 1'b1;
        else                                      grant0 = 1'b1;
      end else if (s0_valid) begin
        grant0 = 1'b1;
      end else if (s1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign s0_ready = grant0;
  assign s1_ready = grant1;

  // Hazard detection against outstanding long-latency results and the write in flight
  always_comb begin
    hz_rd1      = (rd_addr1 != '0) && pending_q[rd_addr1];
    hz_rd2      = (rd_addr2 != '0) && pending_q[rd_addr2];
    hz_waw      = issue_vld && pending_q[issue_addr];
    hz_inflight = rf_we_q && (((rf_addr3_q == rd_addr1) && (rd_addr1 != '0)) ||
                              ((rf_addr3_q == rd_addr2) && (rd_addr2 != '0)));
  end

  assign stall     = !reset && (hz_rd1 || hz_rd2 || hz_waw || hz_inflight);
  assign issue_set = issue_vld && (issue_addr != '0) && !stall;

  // One-hot set/clear requests for the pending scoreboard
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_set) set_vec = NREG'(1) << issue_addr;
    if (grant1)    clr_vec = NREG'(1) << s1_addr;
  end

  // Per-register next state: a new issue outranks a same-cycle retirement; r0 never pends
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pending_d[gi] = 1'b0;
      end else begin : g_bit
        assign pending_d[gi] = set_vec[gi] | (pending_q[gi] & ~clr_vec[gi]);
      end
    end
  endgenerate

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Remember the most recent winner; starts as s1 so s0 takes the first conflict
  always_ff @(posedge clk) begin
    if (reset)       last_grant_q <= 1'b1;
    else if (grant0) last_grant_q <= 1'b0;
    else if (grant1) last_grant_q <= 1'b1;
  end

  // Write stage: register the winner; writes to r0 are accepted but never enabled
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q    <= 1'b0;
      rf_addr3_q <= '0;
      rf_wd3_q   <= '0;
    end else begin
      rf_we_q <= (grant0 && (s0_addr != '0)) || (grant1 && (s1_addr != '0));
      if (grant0) begin
        rf_addr3_q <= s0_addr;
        rf_wd3_q   <= s0_data;
      end else if (grant1) begin
        rf_addr3_q <= s1_addr;
        rf_wd3_q   <= s1_data;
      end
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr3 = rf_addr3_q;
  assign rf_wd3   = rf_wd3_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Bench for rf_wr_arbiter: a round-robin instance checked through a write
// scoreboard plus direct stall/ready checks, and a fixed-priority instance.
module tb_rf_wr_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // shared decode-side inputs
  logic          issue_vld;
  logic [AW-1:0] issue_addr, rd_addr1, rd_addr2;

  // round-robin instance
  logic          s0_valid, s1_valid, s0_ready, s1_ready, stall, rf_we;
  logic [AW-1:0] s0_addr, s1_addr, rf_addr3;
  logic [DW-1:0] s0_data, s1_data, rf_wd3;

  // fixed-priority instance
  logic          f_s0_valid, f_s1_valid, f_s0_ready, f_s1_ready, f_stall, f_rf_we;
  logic [AW-1:0] f_s0_addr, f_s1_addr, f_rf_addr3;
  logic [DW-1:0] f_s0_data, f_s1_data, f_rf_wd3;

  rf_wr_arbiter #(.ROUND_ROBIN(1), .AW(AW), .DW(DW)) dut_rr (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .issue_vld(issue_vld), .issue_addr(issue_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .stall(stall),
    .rf_we(rf_we), .rf_addr3(rf_addr3), .rf_wd3(rf_wd3)
  );

  rf_wr_arbiter #(.ROUND_ROBIN(0), .AW(AW), .DW(DW)) dut_fp (
    .clk(clk), .reset(reset),
    .s0_valid(f_s0_valid), .s0_ready(f_s0_ready), .s0_addr(f_s0_addr), .s0_data(f_s0_data),
    .s1_valid(f_s1_valid), .s1_ready(f_s1_ready), .s1_addr(f_s1_addr), .s1_data(f_s1_data),
    .issue_vld(issue_vld), .issue_addr(issue_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .stall(f_stall),
    .rf_we(f_rf_we), .rf_addr3(f_rf_addr3), .rf_wd3(f_rf_wd3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every regfile write must match the oldest expected write
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got addr=%0d data=0x%0h want=none", rf_addr3, rf_wd3);
      end else begin
        mon_e = exp_q.pop_front();
        $display("wr addr=%0d data=0x%0h exp_addr=%0d exp_data=0x%0h",
                 rf_addr3, rf_wd3, mon_e.a, mon_e.d);
        chk("sb_addr", 32'(rf_addr3), 32'(mon_e.a));
        chk("sb_data", rf_wd3, mon_e.d);
      end
    end
  end

  initial begin
    reset = 1'b1;
    s0_valid = 0; s0_addr = 0; s0_data = 0;
    s1_valid = 0; s1_addr = 0; s1_data = 0;
    f_s0_valid = 0; f_s0_addr = 0; f_s0_data = 0;
    f_s1_valid = 0; f_s1_addr = 0; f_s1_data = 0;
    issue_vld = 0; issue_addr = 0; rd_addr1 = 0; rd_addr2 = 0;

    // reset: requests are ignored and nothing stalls
    s0_valid = 1'b1;
    rd_addr1 = 5'd3;
    cyc(); cyc();
    chk("rst_s0_ready", 32'(s0_ready), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_addr3", 32'(rf_addr3), 0);
    chk("rst_rf_wd3", rf_wd3, 0);
    s0_valid = 1'b0;
    rd_addr1 = 5'd0;
    reset = 1'b0;

    // idle for 5 cycles
    repeat (5) begin
      cyc();
      chk("idle_rf_we", 32'(rf_we), 0);
      chk("idle_stall", 32'(stall), 0);
      chk("idle_s0_ready", 32'(s0_ready), 0);
      chk("idle_s1_ready", 32'(s1_ready), 0);
    end
    // nothing pending: no source register causes a stall
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      #1;
      chk("idle_pending", 32'(stall), 0);
    end
    rd_addr1 = 5'd0;

    // s0 alone
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
    #1;
    chk("s0only_s0_ready", 32'(s0_ready), 1);
    chk("s0only_s1_ready", 32'(s1_ready), 0);
    push(5'd5, 32'hDEADBEEF);
    cyc();
    s0_valid = 1'b0;
    chk("s0only_we_n1", 32'(rf_we), 1);
    chk("s0only_addr_n1", 32'(rf_addr3), 5);
    chk("s0only_data_n1", rf_wd3, 32'hDEADBEEF);
    cyc();
    chk("s0only_we_n2", 32'(rf_we), 0);
    chk("s0only_addr_hold", 32'(rf_addr3), 5);

    // re-reset so both instances start with s0 favoured
    reset = 1'b1;
    cyc();
    reset = 1'b0;

    // conflicts: round-robin alternates, fixed priority keeps s0
    s0_valid = 1; s0_addr = 5'd3; s0_data = 32'hA3;
    s1_valid = 1; s1_addr = 5'd4; s1_data = 32'hB4;
    f_s0_valid = 1; f_s0_addr = 5'd3; f_s0_data = 32'hA3;
    f_s1_valid = 1; f_s1_addr = 5'd4; f_s1_data = 32'hB4;
    #1;
    chk("rr_c1_s0_ready", 32'(s0_ready), 1);
    chk("rr_c1_s1_ready", 32'(s1_ready), 0);
    chk("fp_c1_s0_ready", 32'(f_s0_ready), 1);
    chk("fp_c1_s1_ready", 32'(f_s1_ready), 0);
    push(5'd3, 32'hA3);
    cyc();
    s0_addr = 5'd6; s0_data = 32'h66;
    f_s0_addr = 5'd6; f_s0_data = 32'h66;
    #1;
    chk("rr_c2_s0_ready", 32'(s0_ready), 0);
    chk("rr_c2_s1_ready", 32'(s1_ready), 1);
    chk("fp_c2_s0_ready", 32'(f_s0_ready), 1);
    chk("fp_c2_s1_ready", 32'(f_s1_ready), 0);
    chk("fp_c2_addr", 32'(f_rf_addr3), 3);
    push(5'd4, 32'hB4);
    cyc();
    s1_addr = 5'd8; s1_data = 32'h88;
    f_s0_valid = 0;
    #1;
    chk("rr_c3_s0_ready", 32'(s0_ready), 1);
    chk("rr_c3_s1_ready", 32'(s1_ready), 0);
    chk("fp_c3_s0_ready", 32'(f_s0_ready), 0);
    chk("fp_c3_s1_ready", 32'(f_s1_ready), 1);
    chk("fp_c3_addr", 32'(f_rf_addr3), 6);
    push(5'd6, 32'h66);
    cyc();
    s0_valid = 0;
    f_s1_valid = 0;
    #1;
    chk("rr_c4_s0_ready", 32'(s0_ready), 0);
    chk("rr_c4_s1_ready", 32'(s1_ready), 1);
    chk("fp_c4_we", 32'(f_rf_we), 1);
    chk("fp_c4_addr", 32'(f_rf_addr3), 4);
    chk("fp_c4_data", f_rf_wd3, 32'hB4);
    push(5'd8, 32'h88);
    cyc();
    s1_valid = 0;
    cyc();

    // RAW on an outstanding long-latency result
    issue_vld = 1; issue_addr = 5'd7;
    #1;
    chk("raw_issue_stall", 32'(stall), 0);
    cyc();
    issue_vld = 0; rd_addr1 = 5'd7;
    #1;
    chk("raw_pending_stall", 32'(stall), 1);
    cyc();
    chk("raw_hold_stall", 32'(stall), 1);
    rd_addr1 = 5'd0; issue_vld = 1; issue_addr = 5'd7;
    #1;
    chk("waw_stall", 32'(stall), 1);
    issue_vld = 0; rd_addr1 = 5'd7;
    s1_valid = 1; s1_addr = 5'd7; s1_data = 32'h77;
    #1;
    chk("raw_grant_stall", 32'(stall), 1);
    chk("raw_s1_ready", 32'(s1_ready), 1);
    push(5'd7, 32'h77);
    cyc();
    s1_valid = 0;
    #1;
    chk("raw_inflight_stall", 32'(stall), 1);
    chk("raw_inflight_we", 32'(rf_we), 1);
    cyc();
    chk("raw_clear_stall", 32'(stall), 0);
    rd_addr1 = 5'd0;

    // same-cycle retire and issue of r9: the issue sticks
    s1_valid = 1; s1_addr = 5'd9; s1_data = 32'h99;
    issue_vld = 1; issue_addr = 5'd9;
    #1;
    chk("same_stall", 32'(stall), 0);
    chk("same_s1_ready", 32'(s1_ready), 1);
    push(5'd9, 32'h99);
    cyc();
    s1_valid = 0; issue_vld = 0; rd_addr2 = 5'd9;
    #1;
    chk("same_stall_n1", 32'(stall), 1);
    cyc();
    chk("same_we_n2", 32'(rf_we), 0);
    chk("same_pending_n2", 32'(stall), 1);
    s1_valid = 1; s1_addr = 5'd9; s1_data = 32'h999;
    #1;
    chk("same_retire_ready", 32'(s1_ready), 1);
    push(5'd9, 32'h999);
    cyc();
    s1_valid = 0;
    #1;
    chk("same_retire_inflight", 32'(stall), 1);
    cyc();
    chk("same_retire_clear", 32'(stall), 0);
    rd_addr2 = 5'd0;

    // write to r0: accepted, never enabled
    s0_valid = 1; s0_addr = 5'd0; s0_data = 32'h1234;
    #1;
    chk("r0_s0_ready", 32'(s0_ready), 1);
    cyc();
    s0_valid = 0;
    #1;
    chk("r0_we", 32'(rf_we), 0);

    // reset while an s1 write is in flight
    issue_vld = 1; issue_addr = 5'd12;
    #1;
    chk("mid_issue_stall", 32'(stall), 0);
    cyc();
    issue_vld = 0; rd_addr1 = 5'd12;
    #1;
    chk("mid_pending_stall", 32'(stall), 1);
    rd_addr1 = 5'd0;
    s1_valid = 1; s1_addr = 5'd13; s1_data = 32'h13;
    #1;
    chk("mid_s1_ready", 32'(s1_ready), 1);
    push(5'd13, 32'h13);
    cyc();
    s1_valid = 0; reset = 1; rd_addr1 = 5'd12;
    #1;
    chk("mid_inflight_we", 32'(rf_we), 1);
    chk("mid_reset_stall", 32'(stall), 0);
    cyc();
    chk("mid_dropped_we", 32'(rf_we), 0);
    chk("mid_rst_addr", 32'(rf_addr3), 0);
    reset = 0;
    #1;
    chk("mid_pending_cleared", 32'(stall), 0);
    rd_addr1 = 5'd0;
    cyc();
    cyc();

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the register file's single write port (we/addr3/WD3) between two writeback sources:
  - s0: the in-order pipeline writeback.
  - s1: the long-latency unit writeback (mult/div/load-miss).
- Keeps a 32-entry pending-write scoreboard for registers whose result is still outstanding on s1, and raises a decode stall on hazards.
- Sits between the writeback stage and regfile; its stall output feeds the hazard unit.

Parameters:
- ROUND_ROBIN, 1, 1 = round-robin between s0/s1 on conflict; 0 = fixed priority, s0 always wins.
- AW, 5, register address width (32 registers).
- DW, 32, write data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- s0_valid  in  1  source 0 has a write pending.
- s0_ready  out  1  source 0 write accepted this cycle.
- s0_addr  in  AW  source 0 destination register.
- s0_data  in  DW  source 0 write data.
- s1_valid  in  1  source 1 has a write pending.
- s1_ready  out  1  source 1 write accepted this cycle.
- s1_addr  in  AW  source 1 destination register.
- s1_data  in  DW  source 1 write data.
- issue_vld  in  1  decode issues a long-latency op.
- issue_addr  in  AW  destination of that op.
- rd_addr1  in  AW  decode source register 1.
- rd_addr2  in  AW  decode source register 2.
- stall  out  1  decode must hold this cycle.
- rf_we  out  1  to regfile we.
- rf_addr3  out  AW  to regfile addr3.
- rf_wd3  out  DW  to regfile WD3.

Behaviour:
- Reset:
  - rf_we=0, rf_addr3=0, rf_wd3=0, pending=0, last_grant=1 (so s0 wins the first conflict).
  - s0_ready=s1_ready=0 while reset is high.
- Handshake:
  - A transfer occurs when valid&&ready in the same cycle.
  - A source holds valid/addr/data stable until accepted.
  - ready is combinational from both valids and last_grant.
  - ready never asserts without valid.
- Arbitration:
  - Only one valid: that source is granted.
  - Both valid, ROUND_ROBIN=1: grant the source not equal to last_grant.
  - Both valid, ROUND_ROBIN=0: grant s0.
  - last_grant updates only on a grant.
  - At most one ready high per cycle.
- Write stage:
  - Fixed 1-cycle latency: the granted addr/data are registered into rf_addr3/rf_wd3, and rf_we=1 on the next cycle.
  - No grant: rf_we=0; addr/data hold their previous values.
  - Grant with addr==0: accepted (ready=1) but rf_we stays 0.
- Scoreboard (pending[31:0]):
  - Set: issue_vld && issue_addr!=0 && !stall sets pending[issue_addr] at the edge.
  - Clear: an s1 grant clears pending[s1_addr] at the same edge.
  - Set and clear of the same address in one cycle: set wins (bit remains 1).
  - pending[0] is always 0.
- Stall, combinational, high if any of:
  - pending[rd_addr1] with rd_addr1!=0;
  - pending[rd_addr2] with rd_addr2!=0;
  - issue_vld && pending[issue_addr] (WAW hazard);
  - rf_we==1 and rf_addr3 matches rd_addr1 or rd_addr2 (nonzero). Covers the write still in flight to the regfile; regfile bypass is not relied on.
- Stall is 0 during reset.
- s1 write to a non-pending register: performed normally; scoreboard unchanged.
- Reset mid-transfer: the in-flight rf_we is dropped (rf_we=0 on the cycle after reset is sampled); all pending bits are cleared.

Test Plan:
- Reset, then idle: rf_we=0, stall=0, both ready=0 for 5 cycles; pending==0.
- s0 only, addr=5, data=0xDEADBEEF: s0_ready=1 in cycle N; rf_we=1, rf_addr3=5, rf_wd3=0xDEADBEEF in cycle N+1; rf_we=0 in N+2.
- Both valid for 4 cycles, ROUND_ROBIN=1, s0 addr 3 / s1 addr 4 held until accepted:
  - Grants s0, then s1 (then idle).
  - rf_addr3 sequence 3, 4.
  - With ROUND_ROBIN=0: grants s0 first; s1 granted only after s0_valid drops.
- issue_vld addr=7, then rd_addr1=7:
  - stall=1 until the s1 write to 7 is granted.
  - stall remains 1 the following cycle (rf_we in flight to 7), then 0.
- Same-cycle s1 grant addr=9 and issue_vld addr=9 (pending[9] clear before): pending[9] remains 1 afterwards.
- s0 write addr=0, data=0x1234: s0_ready=1; rf_we stays 0. Then assert reset during an in-flight s1 grant: rf_we=0 and pending==0 on the next cycle.
